// File: rtl/mem_dump_tx.sv
// mem_dump_tx: UART debug read-out of one RAM doubleword.
// Fetches memdata at memadr and sends it MSB byte first, 8N1.
module mem_dump_tx #(
    parameter int N            = 64,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    input  logic [7:0]   req_addr,
    output logic         req_ready,
    output logic [7:0]   memadr,
    input  logic [N-1:0] memdata,
    output logic         tx,
    output logic         busy,
    output logic         done
);

    localparam int NBYTES = N / 8;
    localparam int BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int BDW    = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_START,
        S_DATA,
        S_STOP,
        S_FIN
    } state_t;

    state_t         state_q, state_d;
    logic [7:0]     memadr_q, memadr_d;
    logic [N-1:0]   shreg_q, shreg_d;
    logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [BDW-1:0] baud_cnt_q, baud_cnt_d;
    logic           tx_q, tx_d;

    logic [7:0]     cur_byte;
    logic [2:0]     bit_nxt;
    logic           baud_wrap;
    logic           last_byte;

    assign cur_byte  = shreg_q[N-1 -: 8];
    assign bit_nxt   = bit_cnt_q + 3'd1;
    assign baud_wrap = (baud_cnt_q == BDW'(CLKS_PER_BIT - 1));
    assign last_byte = (byte_cnt_q == BCW'(NBYTES - 1));

    // State and datapath registers; reset parks the line high at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            memadr_q   <= '0;
            shreg_q    <= '0;
            byte_cnt_q <= '0;
            bit_cnt_q  <= '0;
            baud_cnt_q <= '0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            memadr_q   <= memadr_d;
            shreg_q    <= shreg_d;
            byte_cnt_q <= byte_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            baud_cnt_q <= baud_cnt_d;
            tx_q       <= tx_d;
        end
    end

    // Next-state logic: fetch once, then frame each byte with start/stop bits.
    always_comb begin
        state_d    = state_q;
        memadr_d   = memadr_q;
        shreg_d    = shreg_q;
        byte_cnt_d = byte_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        baud_cnt_d = '0;
        tx_d       = tx_q;
        unique case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (req_valid) begin
                    memadr_d = req_addr;
                    state_d  = S_FETCH;
                end
            end
            S_FETCH: begin
                shreg_d    = memdata;
                byte_cnt_d = '0;
                bit_cnt_d  = '0;
                tx_d       = 1'b0;
                state_d    = S_START;
            end
            S_START: begin
                baud_cnt_d = baud_wrap ? '0 : baud_cnt_q + BDW'(1);
                if (baud_wrap) begin
                    bit_cnt_d = '0;
                    tx_d      = cur_byte[0];
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                baud_cnt_d = baud_wrap ? '0 : baud_cnt_q + BDW'(1);
                if (baud_wrap) begin
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d = '0;
                        tx_d      = 1'b1;
                        state_d   = S_STOP;
                    end else begin
                        bit_cnt_d = bit_nxt;
                        tx_d      = cur_byte[bit_nxt];
                    end
                end
            end
            S_STOP: begin
                baud_cnt_d = baud_wrap ? '0 : baud_cnt_q + BDW'(1);
                if (baud_wrap) begin
                    shreg_d = shreg_q << 8;
                    if (last_byte) begin
                        byte_cnt_d = '0;
                        tx_d       = 1'b1;
                        state_d    = S_FIN;
                    end else begin
                        byte_cnt_d = byte_cnt_q + BCW'(1);
                        tx_d       = 1'b0;
                        state_d    = S_START;
                    end
                end
            end
            S_FIN: begin
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    assign req_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_FIN);
    assign memadr    = memadr_q;
    assign tx        = tx_q;

endmodule

// File: tb/tb_mem_dump_tx.sv
// tb_mem_dump_tx: directed bench for mem_dump_tx.
// Decodes the UART line at CLKS_PER_BIT=4 against a RAM model.
module tb_mem_dump_tx;

    localparam int N   = 64;
    localparam int CPB = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic [7:0]    req_addr = '0;
    logic          req_ready;
    logic [7:0]    memadr;
    logic [N-1:0]  memdata;
    logic          tx;
    logic          busy;
    logic          done;

    logic [63:0]   ram [0:255];
    int            cyc = 0;
    int            done_cnt = 0;
    int            checks = 0;
    int            errors = 0;

    mem_dump_tx #(.N(N), .CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .memadr    (memadr),
        .memdata   (memdata),
        .tx        (tx),
        .busy      (busy),
        .done      (done)
    );

    assign memdata = ram[memadr];

    always #5 clk = ~clk;

    // Cycle counter and done-pulse counter.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_req(input logic [7:0] a);
        req_valid = 1'b1;
        req_addr  = a;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic rx_byte(output logic [7:0] b, output int fall_cyc,
                           output bit ok);
        int n = 0;
        b  = '0;
        ok = 1'b1;
        while (tx !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        fall_cyc = cyc;
        if (tx !== 1'b0) begin
            chk("rx_start_timeout", 1, 0);
            ok = 1'b0;
            return;
        end
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        chk("stop_bit", tx, 1);
    endtask

    task automatic rx_dump(output logic [63:0] v, output int fall_cyc,
                           input int clob_idx, input logic [7:0] clob_addr);
        logic [7:0] b;
        int         fc;
        bit         ok;
        v = '0;
        fall_cyc = 0;
        for (int i = 0; i < 8; i++) begin
            rx_byte(b, fc, ok);
            if (!ok) return;
            if (i == 0) fall_cyc = fc;
            v = {v[55:0], b};
            if (i == clob_idx) ram[clob_addr] = '0;
        end
    endtask

    task automatic wait_done(output int c);
        int n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        c = cyc;
        if (done !== 1'b1) chk("done_timeout", 0, 1);
    endtask

    initial begin
        logic [63:0] v;
        int          fc;
        int          dc;
        int          snap;
        bit          moved;

        for (int i = 0; i < 256; i++) ram[i] = 64'(i) * 64'h0101_0101_0101_0101;
        ram[0] = 64'hFF00_FF00_FF00_FF00;
        ram[1] = 64'hA5A5_5A5A_0F0F_F0F0;
        ram[2] = 64'h8000_0000_0000_0001;
        ram[5] = 64'h0123_4567_89AB_CDEF;
        ram[7] = 64'h1122_0033_4455_6677;

        // 1: reset state and quiet idle
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ready", req_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_memadr", memadr, 0);
        moved = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || req_ready !== 1'b1 ||
                done !== 1'b0) moved = 1'b1;
        end
        chk("idle_hold", moved, 0);

        // 2: basic dump with latency
        snap = done_cnt;
        send_req(8'd5);
        chk("t2_memadr", memadr, 5);
        chk("t2_busy", busy, 1);
        rx_dump(v, fc, -1, 8'd0);
        chk("t2_data", v, 64'h0123_4567_89AB_CDEF);
        wait_done(dc);
        chk("t2_latency", dc - fc, 320);
        @(negedge clk);
        chk("t2_ready", req_ready, 1);
        chk("t2_done_cnt", done_cnt - snap, 1);

        // 3: held request gives one dump, next only after done
        snap = done_cnt;
        req_valid = 1'b1;
        req_addr  = 8'd0;
        rx_dump(v, fc, -1, 8'd0);
        chk("t3_data1", v, 64'hFF00_FF00_FF00_FF00);
        wait_done(dc);
        @(negedge clk);
        chk("t3_idle_ready", req_ready, 1);
        chk("t3_idle_busy", busy, 0);
        chk("t3_one_done", done_cnt - snap, 1);
        @(negedge clk);
        chk("t3_refetch_busy", busy, 1);
        req_valid = 1'b0;
        rx_dump(v, fc, -1, 8'd0);
        chk("t3_data2", v, 64'hFF00_FF00_FF00_FF00);
        wait_done(dc);
        repeat (2) @(negedge clk);
        chk("t3_two_done", done_cnt - snap, 2);

        // 4: RAM overwrite mid-dump does not change the data
        send_req(8'd5);
        rx_dump(v, fc, 2, 8'd5);
        chk("t4_data", v, 64'h0123_4567_89AB_CDEF);
        chk("t4_ram_cleared", ram[5], 0);
        wait_done(dc);
        repeat (2) @(negedge clk);

        // 5: reset in byte 2 data bits
        send_req(8'd7);
        fc = 0;
        while (tx !== 1'b0 && fc < 100) begin
            @(negedge clk);
            fc++;
        end
        repeat (90) @(negedge clk);
        chk("t5_pre_tx", tx, 0);
        chk("t5_pre_busy", busy, 1);
        snap = done_cnt;
        reset = 1'b1;
        #1;
        chk("t5_rst_tx", tx, 1);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_done", done, 0);
        @(negedge clk);
        reset = 1'b0;
        moved = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) moved = 1'b1;
        end
        chk("t5_quiet", moved, 0);
        chk("t5_no_done", done_cnt - snap, 0);
        send_req(8'd7);
        rx_dump(v, fc, -1, 8'd0);
        chk("t5_data", v, 64'h1122_0033_4455_6677);
        wait_done(dc);
        repeat (2) @(negedge clk);

        // 6: back-to-back requests
        snap = done_cnt;
        send_req(8'd1);
        rx_dump(v, fc, -1, 8'd0);
        chk("t6_data1", v, 64'hA5A5_5A5A_0F0F_F0F0);
        wait_done(dc);
        @(negedge clk);
        send_req(8'd2);
        chk("t6_memadr", memadr, 2);
        rx_dump(v, fc, -1, 8'd0);
        chk("t6_data2", v, 64'h8000_0000_0000_0001);
        chk("t6_gap_min", (fc - dc) >= 2, 1);
        chk("t6_gap", fc - dc, 3);
        wait_done(dc);
        repeat (2) @(negedge clk);
        chk("t6_done_cnt", done_cnt - snap, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
